// File: rtl/ccff_loader.sv
// Configuration-chain loader: streams WORD_W-bit bitstream words MSB-first
// into a CHAIN_LEN-long shift chain, optionally comparing the bits that come
// back out of the chain tail against the new stream (verify pass).
//
// Stream handshake: a word transfers on a rising prog_clk edge where
// s_valid=1 and s_ready=1; s_ready depends only on the loader state, never
// on s_valid, and the source holds s_data stable while s_valid=1 and s_ready=0.
module ccff_loader #(
  parameter  int CHAIN_LEN = 64,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              verify,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        err_count,
  output logic [CNT_W-1:0]  bit_count,
  output logic [1:0]        state_dbg
);

  localparam int WCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WCNT_W-1:0] LAST_POS = WCNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state;
  logic                mode_q;   // 1 = verify pass
  logic [WORD_W-1:0]   sreg;     // bits of the current word still to send, MSB next
  logic [WCNT_W-1:0]   wcnt;     // position of the bit now on ccff_head within its word

  assign state_dbg = state;

  // Pass sequencer: all outputs are registered alongside the state so that
  // ccff_head / ccff_shift_en are glitch-free for the gated chain clock.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state         <= ST_IDLE;
      mode_q        <= 1'b0;
      sreg          <= '0;
      wcnt          <= '0;
      s_ready       <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_count     <= 8'd0;
      bit_count     <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Cancel: counters and error flags freeze, no completion pulse.
        if (state != ST_IDLE) begin
          state         <= ST_IDLE;
          s_ready       <= 1'b0;
          ccff_head     <= 1'b0;
          ccff_shift_en <= 1'b0;
          busy          <= 1'b0;
        end
      end else begin
        // The bit leaving the tail on this edge pairs with the bit entering the head.
        if (ccff_shift_en && mode_q && (ccff_tail != ccff_head)) begin
          error <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
        case (state)
          ST_IDLE: begin
            if (start) begin
              state     <= ST_FETCH;
              mode_q    <= verify;
              bit_count <= '0;
              error     <= 1'b0;
              err_count <= 8'd0;
              busy      <= 1'b1;
              s_ready   <= 1'b1;
            end
          end
          ST_FETCH: begin
            if (s_valid) begin
              ccff_head     <= s_data[WORD_W-1];
              sreg          <= s_data << 1;
              wcnt          <= '0;
              ccff_shift_en <= 1'b1;
              s_ready       <= 1'b0;
              state         <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            bit_count <= bit_count + CNT_W'(1);
            if (bit_count == LAST_BIT) begin
              // Chain full: any remaining low bits of this word are dropped.
              state         <= ST_DONE;
              ccff_shift_en <= 1'b0;
              ccff_head     <= 1'b0;
              done          <= 1'b1;
            end else if (wcnt == LAST_POS) begin
              state         <= ST_FETCH;
              ccff_shift_en <= 1'b0;
              ccff_head     <= 1'b0;
              s_ready       <= 1'b1;
            end else begin
              ccff_head <= sreg[WORD_W-1];
              sreg      <= sreg << 1;
              wcnt      <= wcnt + WCNT_W'(1);
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 64: number of flip-flops in the target configuration chain; legal range 1..65535.
REQ-002 Parameter WORD_W, default 8: bitstream word width; legal range 1..32.
REQ-003 prog_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 pReset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle request to begin a pass; ignored while busy=1.
REQ-006 verify  in  1  sampled with start: 0 = load pass, 1 = verify pass.
REQ-007 abort  in  1  synchronous cancel of the current pass.
REQ-008 s_data  in  WORD_W  bitstream word, MSB shifted first.
REQ-009 s_valid  in  1  s_data valid.
REQ-010 s_ready  out  1  loader accepts s_data on an edge where s_valid=1 and s_ready=1.
REQ-011 ccff_head  out  1  serial bit to the chain head; registered.
REQ-012 ccff_shift_en  out  1  registered enable that gates prog_clk to the chain; chain shifts only on edges where it is 1.
REQ-013 ccff_tail  in  1  chain tail, used for verify compare.
REQ-014 busy  out  1  high from the cycle after an accepted start until DONE exits.
REQ-015 done  out  1  one-cycle pulse at pass completion.
REQ-016 error  out  1  sticky verify-mismatch flag; cleared by an accepted start.
REQ-017 err_count  out  8  saturating mismatch count; cleared by an accepted start.
REQ-018 bit_count  out  clog2(CHAIN_LEN+1)  number of bits shifted in the current pass.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, SHIFT and DONE.
REQ-020 IDLE->FETCH on start=1; mode latched; bit_count, error and err_count cleared at the same edge.
REQ-021 FETCH: s_ready=1 and ccff_shift_en=0; on handshake, load s_data into the shift register and go to SHIFT.
REQ-022 SHIFT: ccff_shift_en=1 and ccff_head = current word MSB; each cycle, shift left by one and increment bit_count.
REQ-023 SHIFT->FETCH after WORD_W bits when bit_count < CHAIN_LEN; SHIFT->DONE the cycle the CHAIN_LEN-th bit is shifted, even mid-word.
REQ-024 Unused low bits of a final partial word SHALL be discarded, with no extra shift.
REQ-025 DONE lasts one cycle with done=1, ccff_shift_en=0 and s_ready=0, then returns to IDLE.
REQ-026 Throughput: per word, 1 FETCH cycle (minimum, more when s_valid=0) plus WORD_W shift cycles; start to first shift is at least 2 cycles.
REQ-027 Verify compare: on each edge with ccff_shift_en=1 in verify mode, if ccff_tail != ccff_head then set error and increment err_count, which saturates at 255.
REQ-028 In load mode, no compare takes place and error/err_count stay 0.
REQ-029 abort=1 in any state other than IDLE SHALL force IDLE at the next edge, with ccff_shift_en=0 from that edge onward, no done pulse, and error/err_count/bit_count held.
REQ-030 abort and start asserted together in IDLE: abort wins and start is ignored.
REQ-031 s_ready SHALL be 0 in every state except FETCH.

Reset
REQ-032 pReset_n=0 SHALL immediately force IDLE and drive these outputs to 0: ccff_head, ccff_shift_en, s_ready, busy, done, error, err_count and bit_count.
REQ-033 A reset mid-pass SHALL not produce a done pulse; the chain contents are then undefined and software reloads.

Verification (CHAIN_LEN=16, WORD_W=8 unless stated; chain modelled as CHAIN_LEN shift FFs clocked by prog_clk & ccff_shift_en)
REQ-034 Load 0xA5 then 0x3C -> ccff_head on 16 enabled edges = 1010 0101 0011 1100; done pulses once; bit_count=16; error=0.
REQ-035 Verify pass with 0xA5, 0x3C after REQ-034 -> error=0, err_count=0; verify pass with 0xA5, 0x3D -> error=1, err_count=1.
REQ-036 CHAIN_LEN=12, load 0xFF then 0xF0 -> exactly 12 enabled edges; s_ready=0 after the second word; done 1 cycle after the 12th shift.
REQ-037 s_valid deasserted for 5 cycles between words -> ccff_shift_en=0 throughout the gap and chain model contents unchanged.
REQ-038 Mid-SHIFT events -> abort: IDLE next cycle, no done; pReset_n low: ccff_shift_en and busy 0 immediately.
REQ-039 Verify pass with all-ones stream against a zeroed chain of 300 bits (CHAIN_LEN=300) -> err_count saturates at 255, error=1.
